// File: rtl/mem_io_responder.sv
// mem_io_responder: SLC-3 bus memory responder with read wait states, byte-lane writes and one I/O word.
// Optional IO_SYNC_EN: switches pass a 2-flop synchronizer before being read.
module mem_io_responder #(
  parameter int          DEPTH    = 1024,
  parameter int          READ_LAT = 2,
  parameter logic [19:0] IO_ADDR  = 20'h0FFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [19:0] A,
  input  logic        CE,
  input  logic        OE,
  input  logic        WE,
  input  logic        UB,
  input  logic        LB,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic        Data_oe,
  output logic        Mem_ready,
  input  logic [15:0] Switches,
  output logic [15:0] Hex_data
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_HOLD, WRITE} state_t;
  state_t state;
  logic [19:0] a_q;
  logic ub_q, lb_q;
  logic [15:0] din_q;
  logic [3:0] cnt;
  logic [15:0] mem [DEPTH];
  logic [15:0] sw, rd_word;
  logic is_io, mapped;
`ifdef IO_SYNC_EN
  logic [15:0] sw_s1, sw_s2;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= Switches;
      sw_s2 <= sw_s1;
    end
  end
  assign sw = sw_s2;
`else
  assign sw = Switches;
`endif
  // I/O decode wins even when IO_ADDR also falls inside the array
  always_comb begin
    is_io   = a_q == IO_ADDR;
    mapped  = a_q < 20'(DEPTH);
    rd_word = is_io ? sw : mapped ? mem[a_q[AW-1:0]] : 16'h0000;
  end
  always_ff @(posedge Clk) begin
    if (!Reset && state == WRITE && mapped && !is_io) begin
      if (!lb_q) mem[a_q[AW-1:0]][7:0] <= din_q[7:0];
      if (!ub_q) mem[a_q[AW-1:0]][15:8] <= din_q[15:8];
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      Data_out  <= '0;
      Data_oe   <= 1'b0;
      Mem_ready <= 1'b0;
      Hex_data  <= '0;
      cnt       <= '0;
      a_q       <= '0;
      ub_q      <= 1'b1;
      lb_q      <= 1'b1;
      din_q     <= '0;
    end else begin
      Mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          a_q   <= A;
          ub_q  <= UB;
          lb_q  <= LB;
          din_q <= Data_in;
          cnt   <= 4'(READ_LAT - 1);
          if (!CE && !WE) state <= WRITE;
          else if (!CE && !OE) state <= READ_WAIT;
        end
        READ_WAIT: begin
          if (CE || OE) state <= IDLE;
          else if (cnt == 4'd0) begin
            Data_out  <= rd_word;
            Data_oe   <= 1'b1;
            Mem_ready <= 1'b1;
            state     <= READ_HOLD;
          end else cnt <= cnt - 4'd1;
        end
        READ_HOLD: begin
          if (CE || OE) begin
            Data_oe <= 1'b0;
            state   <= IDLE;
          end
        end
        WRITE: begin
          Mem_ready <= 1'b1;
          state     <= IDLE;
          if (is_io) begin
            if (!lb_q) Hex_data[7:0] <= din_q[7:0];
            if (!ub_q) Hex_data[15:8] <= din_q[15:8];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: scoreboard bench for mem_io_responder (reads, lane writes, I/O word, abort, reset).
module tb_mem_io_responder;
  localparam int DEPTH = 1024;
  localparam int READ_LAT = 2;
  localparam logic [19:0] IO_ADDR = 20'h0FFFF;
  logic Clk = 0, Reset;
  logic [19:0] A;
  logic CE, OE, WE, UB, LB;
  logic [15:0] Data_in, Data_out, Switches, Hex_data;
  logic Data_oe, Mem_ready;
  int checks = 0, errors = 0;
  logic [15:0] model [DEPTH];
  logic [15:0] hex_m = 16'h0000;
  logic [15:0] exp_q [$];
  mem_io_responder #(.DEPTH(DEPTH), .READ_LAT(READ_LAT), .IO_ADDR(IO_ADDR)) dut (
    .Clk(Clk), .Reset(Reset), .A(A), .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
    .Data_in(Data_in), .Data_out(Data_out), .Data_oe(Data_oe), .Mem_ready(Mem_ready),
    .Switches(Switches), .Hex_data(Hex_data)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic idle_bus();
    CE = 1; OE = 1; WE = 1; UB = 1; LB = 1;
  endtask
  task automatic do_write(input logic [19:0] addr, input logic [15:0] d, input logic ub, input logic lb, input logic oe);
    A = addr; Data_in = d; UB = ub; LB = lb; OE = oe; CE = 0; WE = 0;
    tick();
    check("wr_oe_accept", Data_oe, 0);
    idle_bus();
    tick();
    check("wr_ready", Mem_ready, 1);
    check("wr_oe_commit", Data_oe, 0);
    if (addr == IO_ADDR) begin
      if (!lb) hex_m[7:0] = d[7:0];
      if (!ub) hex_m[15:8] = d[15:8];
    end else if (addr < 20'(DEPTH)) begin
      if (!lb) model[addr[9:0]][7:0] = d[7:0];
      if (!ub) model[addr[9:0]][15:8] = d[15:8];
    end
  endtask
  task automatic do_read(input logic [19:0] addr, input string tag, input bit rst_in_hold);
    int n = 0;
    logic got = 0, oe_early = 0;
    logic [15:0] held;
    exp_q.push_back(addr == IO_ADDR ? Switches : addr < 20'(DEPTH) ? model[addr[9:0]] : 16'h0000);
    A = addr; CE = 0; OE = 0; WE = 1; UB = 0; LB = 0;
    tick();
    A = 20'h00BAD;
    while (!got && n < 20) begin
      tick();
      n++;
      oe_early |= Data_oe & ~Mem_ready;
      got = Mem_ready;
    end
    check("rd_latency", n, READ_LAT);
    check("rd_oe_early", oe_early, 0);
    if (exp_q.size() == 0) check("rd_queue_empty", 1, 0);
    else check(tag, Data_out, exp_q.pop_front());
    check("rd_oe_valid", Data_oe, 1);
    held = Data_out;
    tick();
    check("rd_hold_data", Data_out, held);
    check("rd_hold_oe", Data_oe, 1);
    check("rd_pulse", Mem_ready, 0);
    if (rst_in_hold) begin
      Reset = 1;
      tick();
      Reset = 0;
      check("rst_hold_oe", Data_oe, 0);
      check("rst_hold_data", Data_out, 0);
      check("rst_hold_ready", Mem_ready, 0);
      hex_m = 16'h0000;
      idle_bus();
    end else begin
      idle_bus();
      tick();
      check("rd_release_oe", Data_oe, 0);
    end
  endtask
  initial begin
    bit seen;
    Reset = 1; A = '0; Data_in = '0; Switches = '0;
    idle_bus();
    repeat (2) tick();
    check("rst_data_out", Data_out, 0);
    check("rst_data_oe", Data_oe, 0);
    check("rst_ready", Mem_ready, 0);
    check("rst_hex", Hex_data, 0);
    Reset = 0;
    tick();
    do_write(20'h00010, 16'hBEEF, 0, 0, 1);
    do_read(20'h00010, "t1_read", 0);
    do_write(20'h00020, 16'h1234, 0, 0, 1);
    do_read(20'h00020, "t2_init", 0);
    do_write(20'h00020, 16'hABCD, 1, 0, 1);
    do_read(20'h00020, "t2_low_lane", 0);
    do_write(20'h00020, 16'h5600, 0, 1, 1);
    do_read(20'h00020, "t2_high_lane", 0);
    do_write(20'h00020, 16'hFFFF, 1, 1, 1);
    do_read(20'h00020, "t2_no_lane", 0);
    check("t2_const", model[10'h020], 16'h56CD);
    do_write(20'(IO_ADDR % DEPTH), 16'h7777, 0, 0, 1);
    Switches = 16'h0F0F;
    repeat (3) tick();
    do_read(IO_ADDR, "t3_switches", 0);
    do_write(IO_ADDR, 16'h3C5A, 0, 0, 1);
    check("t3_hex", Hex_data, hex_m);
    check("t3_hex_const", Hex_data, 16'h3C5A);
    do_read(20'(IO_ADDR % DEPTH), "t3_alias_kept", 0);
    Switches = 16'hA5A5;
    repeat (3) tick();
    do_read(IO_ADDR, "t3_switch_change", 0);
    A = 20'h00010; CE = 0; OE = 0; WE = 1;
    tick();
    idle_bus();
    seen = 0;
    repeat (5) begin
      tick();
      seen |= Mem_ready | Data_oe;
    end
    check("t4_abort", seen, 0);
    do_read(20'h00010, "t4_after_abort", 0);
    do_write(20'h00030, 16'h4242, 0, 0, 0);
    do_read(20'h00030, "t5_oe_we_write", 0);
    do_read(20'(DEPTH), "t5_unmapped_rd", 0);
    do_write(20'h00000, 16'h1111, 0, 0, 1);
    do_write(20'(DEPTH), 16'h9999, 0, 0, 1);
    do_read(20'h00000, "t5_word0_kept", 0);
    do_read(20'h00010, "t5_word10_kept", 0);
    do_read(20'h00020, "t6_rst_in_hold", 1);
    check("t6_hex_reset", Hex_data, 0);
    Reset = 1;
    A = 20'h00010; Data_in = 16'h0000; CE = 0; WE = 0; OE = 1; UB = 0; LB = 0;
    tick();
    Reset = 0;
    idle_bus();
    check("t6_rst_wr_ready", Mem_ready, 0);
    check("t6_rst_wr_oe", Data_oe, 0);
    tick();
    check("t6_no_commit_ready", Mem_ready, 0);
    do_read(20'h00010, "t6_word_kept", 0);
    check("t6_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
